// File: rtl/pwm_ramp_controller.sv
// ---------------------------------------------------------------------------
// pwm_ramp_controller
//
// Walks the PWM duty cycle toward a target written over SPI in bounded
// steps.  Steps are only taken on PWM period boundaries (period_tick), so
// the PWM peripheral never sees its duty value change mid-period.
//
// Ports:
//   clk, rst_n    : single clock, asynchronous active-low reset
//   target_duty   : requested duty cycle (sampled when target_valid=1)
//   target_valid  : one-cycle write strobe for target_duty
//   step_size     : duty increment per step (0 behaves as 1)
//   rate_div      : one step every rate_div+1 period ticks
//   bypass        : apply a new target immediately, without ramping
//   period_tick   : one-cycle pulse at each PWM counter wrap
//   duty_out      : registered duty cycle to the PWM peripheral
//   busy          : high while a ramp is in progress
//   done          : one-cycle pulse when duty_out reaches the latched target
//   state_dbg     : current FSM state (0 idle, 1 ramp up, 2 ramp down)
//
// Handshake: target_valid is a fire-and-forget strobe with no ready; every
// strobe is accepted in the cycle it is high, and it wins over a
// period_tick in the same cycle (the tick is then dropped entirely).
// ---------------------------------------------------------------------------
module pwm_ramp_controller #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     target_duty,
    input  logic                 target_valid,
    input  logic [3:0]           step_size,
    input  logic [DIV_WIDTH-1:0] rate_div,
    input  logic                 bypass,
    input  logic                 period_tick,
    output logic [WIDTH-1:0]     duty_out,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic [WIDTH-1:0]     duty_q,    duty_d;
    logic [WIDTH-1:0]     target_q,  target_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    // Step arithmetic is done one bit wider than the duty value so that an
    // overshoot past the top of the range is visible and clamped, never
    // wrapped.
    logic [WIDTH:0]       step_eff;
    logic [WIDTH:0]       up_sum;
    logic [WIDTH:0]       dn_diff;
    logic [WIDTH-1:0]     up_next;
    logic [WIDTH-1:0]     dn_next;
    logic [WIDTH-1:0]     step_next;

    always_comb begin
        step_eff = {{(WIDTH-3){1'b0}}, step_size};
        if (step_size == 4'd0) begin
            step_eff = (WIDTH+1)'(1);
        end

        up_sum  = {1'b0, duty_q} + step_eff;
        up_next = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[WIDTH-1:0];

        // Subtraction floors at zero before clamping to the target.
        dn_diff = ({1'b0, duty_q} >= step_eff) ? ({1'b0, duty_q} - step_eff)
                                               : '0;
        dn_next = (dn_diff <= {1'b0, target_q}) ? target_q : dn_diff[WIDTH-1:0];

        step_next = (state_q == ST_RAMP_UP) ? up_next : dn_next;
    end

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = target_q;
        div_cnt_d = div_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (target_valid) begin
            target_d = target_duty;
            if (bypass) begin
                duty_d  = target_duty;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (target_duty == duty_q) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = (target_duty > duty_q) ? ST_RAMP_UP : ST_RAMP_DOWN;
                busy_d  = 1'b1;
                // A retarget mid-ramp keeps the divider phase; only a fresh
                // ramp out of idle restarts it.
                if (state_q == ST_IDLE) begin
                    div_cnt_d = '0;
                end
            end
        end else if (period_tick && (state_q != ST_IDLE)) begin
            if (div_cnt_q == rate_div) begin
                div_cnt_d = '0;
                duty_d    = step_next;
                if (step_next == target_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            duty_q    <= '0;
            target_q  <= '0;
            div_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            div_cnt_q <= div_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign duty_out  = duty_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
module tb_pwm_ramp_controller;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] target_duty = '0;
    logic       target_valid = 1'b0;
    logic [3:0] step_size = '0;
    logic [7:0] rate_div = '0;
    logic       bypass = 1'b0;
    logic       period_tick = 1'b0;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    pwm_ramp_controller #(.WIDTH(8), .DIV_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .target_duty  (target_duty),
        .target_valid (target_valid),
        .step_size    (step_size),
        .rate_div     (rate_div),
        .bypass       (bypass),
        .period_tick  (period_tick),
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Check the three outputs together.
    task automatic check_out(input string tag, input logic [7:0] d,
                             input logic b, input logic dn);
        check_val({tag, ".duty"}, 32'(duty_out), 32'(d));
        check_val({tag, ".busy"}, 32'(busy), 32'(b));
        check_val({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    // ---------------- driver ----------------
    // Inputs are applied just after a rising edge, held for one cycle, and
    // the outputs are examined 1 time unit after the next rising edge.
    task automatic cyc(input logic tv, input logic [7:0] td, input logic tk);
        target_valid = tv;
        target_duty  = td;
        period_tick  = tk;
        @(posedge clk);
        #1;
        target_valid = 1'b0;
        period_tick  = 1'b0;
    endtask

    task automatic write_target(input logic [7:0] td);
        cyc(1'b1, td, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #1;
        check_out("reset", 8'h00, 1'b0, 1'b0);
        check_val("reset.state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // Ramp up 0 -> 0x10, step 4, every tick
        step_size = 4'd4;
        rate_div  = 8'd0;
        write_target(8'h10);
        check_out("up.start", 8'h00, 1'b1, 1'b0);
        check_val("up.state", 32'(state_dbg), 32'd1);
        exp_q.push_back(32'h04);
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h0C);
        exp_q.push_back(32'h10);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            check_val("up.duty", 32'(duty_out), exp_v);
            check_val("up.done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
            check_val("up.busy", 32'(busy), (i == 3) ? 32'd0 : 32'd1);
            idle();
            check_val("up.done_gap", 32'(done), 32'd0);
        end
        tick();
        check_out("up.idle_tick", 8'h10, 1'b0, 1'b0);

        // Overshoot clamp with divider: 0xFA -> 0xFF, step 15, rate_div 2
        bypass = 1'b1;
        write_target(8'hFA);
        check_out("byp.fa", 8'hFA, 1'b0, 1'b1);
        bypass    = 1'b0;
        step_size = 4'd15;
        rate_div  = 8'd2;
        write_target(8'hFF);
        check_out("ovr.start", 8'hFA, 1'b1, 1'b0);
        tick();
        check_out("ovr.t1", 8'hFA, 1'b1, 1'b0);
        tick();
        check_out("ovr.t2", 8'hFA, 1'b1, 1'b0);
        tick();
        check_out("ovr.t3", 8'hFF, 1'b0, 1'b1);
        idle();
        check_out("ovr.after", 8'hFF, 1'b0, 1'b0);

        // Retarget mid-ramp with reversal
        bypass = 1'b1;
        write_target(8'h28);
        bypass    = 1'b0;
        step_size = 4'd8;
        rate_div  = 8'd0;
        write_target(8'h80);
        tick();
        check_out("rev.up", 8'h30, 1'b1, 1'b0);
        write_target(8'h20);
        check_out("rev.retarget", 8'h30, 1'b1, 1'b0);
        check_val("rev.state", 32'(state_dbg), 32'd2);
        tick();
        check_out("rev.d1", 8'h28, 1'b1, 1'b0);
        tick();
        check_out("rev.d2", 8'h20, 1'b0, 1'b1);
        idle();
        check_out("rev.after", 8'h20, 1'b0, 1'b0);

        // Collision: strobe and tick together; step 0 behaves as 1
        step_size = 4'd0;
        rate_div  = 8'd1;
        write_target(8'h24);
        tick();
        check_out("col.t1", 8'h20, 1'b1, 1'b0);
        cyc(1'b1, 8'h26, 1'b1);
        check_out("col.same", 8'h20, 1'b1, 1'b0);
        tick();
        check_out("col.t2", 8'h21, 1'b1, 1'b0);
        tick();
        check_out("col.t3", 8'h21, 1'b1, 1'b0);
        tick();
        check_out("col.t4", 8'h22, 1'b1, 1'b0);

        // Bypass mid-ramp, then equal target without bypass
        bypass = 1'b1;
        write_target(8'h99);
        check_out("byp.99", 8'h99, 1'b0, 1'b1);
        bypass = 1'b0;
        idle();
        check_out("byp.after", 8'h99, 1'b0, 1'b0);
        write_target(8'h99);
        check_out("eq.99", 8'h99, 1'b0, 1'b1);
        check_val("eq.state", 32'(state_dbg), 32'd0);
        tick();
        check_out("eq.tick", 8'h99, 1'b0, 1'b0);

        // Ramp down floors at zero: 0x05 -> 0x00, step 15
        bypass = 1'b1;
        write_target(8'h05);
        bypass    = 1'b0;
        step_size = 4'd15;
        rate_div  = 8'd0;
        write_target(8'h00);
        check_out("floor.start", 8'h05, 1'b1, 1'b0);
        tick();
        check_out("floor.t1", 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-ramp at 0x40
        bypass = 1'b1;
        write_target(8'h40);
        bypass    = 1'b0;
        step_size = 4'd1;
        write_target(8'h80);
        check_out("rst.pre", 8'h40, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst.async", 8'h00, 1'b0, 1'b0);
        check_val("rst.state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check_out("rst.ticks", 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
